// File: rtl/pci_ctrl_pkg.sv
// Shared types and constants for the PCI_COM_LPT register-bus control path.
package pci_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PCI_RUN,
    ST_PCI_WAIT,
    ST_LOC_RUN,
    ST_LOC_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_CFG_RD = 4'b1010;
  localparam logic [3:0] CMD_CFG_WR = 4'b1011;

  localparam int PCI_MAX_LATENCY = 16;

  // Lowest pending byte lane; callers never pass an empty mask.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/pci_rr_arb2.sv
// Two-requester round-robin arbiter; last_grant commits only when an access completes.
module pci_rr_arb2 #(
  parameter bit LOC_FIRST = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_pci,
  input  logic req_loc,
  input  logic en,
  input  logic upd,
  input  logic upd_loc,
  output logic gnt_pci,
  output logic gnt_loc
);

  logic last_loc;

  // Seeding last_loc opposite to the preferred winner makes the first tie go its way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_loc <= ~LOC_FIRST;
    else if (upd) last_loc <= upd_loc;
  end

  always_comb begin
    gnt_pci = en & req_pci & (~req_loc | last_loc);
    gnt_loc = en & req_loc & (~req_pci | ~last_loc);
  end

endmodule

// File: rtl/pci_regbus_sequencer.sv
// Sequences PCI dword and local byte accesses onto the 8-bit register bus,
// splitting PCI dwords into one bus cycle per enabled byte lane.
module pci_regbus_sequencer
  import pci_ctrl_pkg::*;
#(
  parameter bit LOC_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pci_req,
  input  logic        pci_wr,
  input  logic [5:0]  pci_addr,
  input  logic [3:0]  pci_be_n,
  input  logic [31:0] pci_wdata,
  input  logic        pci_abort,
  output logic        pci_ack,
  output logic [31:0] pci_rdata,
  input  logic        loc_req,
  input  logic        loc_wr,
  input  logic [7:0]  loc_addr,
  input  logic [7:0]  loc_wdata,
  output logic        loc_ack,
  output logic [7:0]  loc_rdata,
  output logic [7:0]  rb_addr,
  output logic [7:0]  rb_wdata,
  output logic        rb_wr,
  output logic        rb_rd,
  input  logic [7:0]  rb_rdata
);

  state_t      state, state_nxt;
  logic        gnt_pci, gnt_loc;
  logic        own_loc_p0, wr_p0;
  logic [3:0]  lanes_p0;
  logic [5:0]  addr_p0;
  logic [31:0] wdata_p0;
  logic [7:0]  laddr_p0, lwdata_p0;
  logic        cap_vld_p1;
  logic [1:0]  cap_lane_p1;
  logic [1:0]  cur_lane;
  logic [3:0]  rest;

  pci_rr_arb2 #(.LOC_FIRST(LOC_FIRST)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_pci (pci_req),
    .req_loc (loc_req),
    .en      (state == ST_IDLE),
    .upd     (state == ST_DONE),
    .upd_loc (own_loc_p0),
    .gnt_pci (gnt_pci),
    .gnt_loc (gnt_loc)
  );

  always_comb begin
    cur_lane = first_lane(lanes_p0);
    rest     = lanes_p0 & ~(4'b0001 << cur_lane);
  end

  // Stage p0: grant latches the access; p1: read byte lands one cycle after its strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      own_loc_p0  <= 1'b0;
      wr_p0       <= 1'b0;
      lanes_p0    <= 4'h0;
      cap_vld_p1  <= 1'b0;
      cap_lane_p1 <= 2'd0;
      pci_rdata   <= 32'h0;
      loc_rdata   <= 8'h0;
    end else begin
      state       <= state_nxt;
      cap_vld_p1  <= (state == ST_PCI_RUN) && !wr_p0;
      cap_lane_p1 <= cur_lane;
      if (gnt_pci) begin
        own_loc_p0 <= 1'b0;
        wr_p0      <= pci_wr;
        lanes_p0   <= ~pci_be_n;
      end else if (gnt_loc) begin
        own_loc_p0 <= 1'b1;
        wr_p0      <= loc_wr;
      end else if (state == ST_PCI_RUN) begin
        lanes_p0   <= rest;
      end
      if (gnt_pci)         pci_rdata <= 32'h0;
      else if (cap_vld_p1) pci_rdata[{cap_lane_p1, 3'b000} +: 8] <= rb_rdata;
      if (state == ST_LOC_WAIT) loc_rdata <= rb_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_pci) begin
      addr_p0  <= pci_addr;
      wdata_p0 <= pci_wdata;
    end
    if (gnt_loc) begin
      laddr_p0  <= loc_addr;
      lwdata_p0 <= loc_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_pci)      state_nxt = (pci_be_n == 4'hF) ? ST_DONE : ST_PCI_RUN;
        else if (gnt_loc) state_nxt = ST_LOC_RUN;
      end
      ST_PCI_RUN: begin
        if (pci_abort)      state_nxt = ST_IDLE;
        else if (rest == 0) state_nxt = wr_p0 ? ST_DONE : ST_PCI_WAIT;
      end
      ST_PCI_WAIT: state_nxt = pci_abort ? ST_IDLE : ST_DONE;
      ST_LOC_RUN:  state_nxt = wr_p0 ? ST_DONE : ST_LOC_WAIT;
      ST_LOC_WAIT: state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rb_addr  = 8'h0;
    rb_wdata = 8'h0;
    rb_wr    = 1'b0;
    rb_rd    = 1'b0;
    pci_ack  = 1'b0;
    loc_ack  = 1'b0;
    case (state)
      ST_PCI_RUN: begin
        rb_addr  = {addr_p0, cur_lane};
        rb_wdata = wr_p0 ? wdata_p0[{cur_lane, 3'b000} +: 8] : 8'h0;
        rb_wr    = wr_p0;
        rb_rd    = !wr_p0;
      end
      ST_LOC_RUN: begin
        rb_addr  = laddr_p0;
        rb_wdata = wr_p0 ? lwdata_p0 : 8'h0;
        rb_wr    = wr_p0;
        rb_rd    = !wr_p0;
      end
      ST_DONE: begin
        pci_ack = !own_loc_p0;
        loc_ack = own_loc_p0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pci_regbus_sequencer.sv
// Directed bench for pci_regbus_sequencer with a byte-wide register-file model.
module tb_pci_regbus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pci_req, pci_wr, pci_abort, pci_ack;
  logic [5:0]  pci_addr;
  logic [3:0]  pci_be_n;
  logic [31:0] pci_wdata, pci_rdata;
  logic        loc_req, loc_wr, loc_ack;
  logic [7:0]  loc_addr, loc_wdata, loc_rdata;
  logic [7:0]  rb_addr, rb_wdata, rb_rdata;
  logic        rb_wr, rb_rd;

  int tests = 0;
  int fails = 0;

  logic [7:0] regf [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always #5 clk = ~clk;

  pci_regbus_sequencer #(.LOC_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset),
    .pci_req(pci_req), .pci_wr(pci_wr), .pci_addr(pci_addr), .pci_be_n(pci_be_n),
    .pci_wdata(pci_wdata), .pci_abort(pci_abort), .pci_ack(pci_ack), .pci_rdata(pci_rdata),
    .loc_req(loc_req), .loc_wr(loc_wr), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_ack(loc_ack), .loc_rdata(loc_rdata),
    .rb_addr(rb_addr), .rb_wdata(rb_wdata), .rb_wr(rb_wr), .rb_rd(rb_rd), .rb_rdata(rb_rdata)
  );

  // Register file: writes land on the edge, read data appears the cycle after rb_rd.
  always @(posedge clk) begin
    if (ld_en)      regf[ld_addr] <= ld_data;
    else if (rb_wr) regf[rb_addr] <= rb_wdata;
    rb_rdata <= rb_rd ? regf[rb_addr] : 8'h5A;
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic pci_drive(input logic wr, input logic [5:0] a, input logic [3:0] be_n,
                           input logic [31:0] d);
    @(posedge clk); #1;
    pci_req = 1'b1; pci_wr = wr; pci_addr = a; pci_be_n = be_n; pci_wdata = d;
  endtask

  task automatic loc_drive(input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    loc_req = 1'b1; loc_wr = wr; loc_addr = a; loc_wdata = d;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    tests++;
    if ({rb_wr, rb_rd, pci_ack, loc_ack, rb_addr, rb_wdata, pci_rdata, loc_rdata} !== 58'h0) begin
      fails++;
      $display("FAIL reset_hold: wr=%b rd=%b pack=%b lack=%b addr=%h prd=%h, required all 0",
               rb_wr, rb_rd, pci_ack, loc_ack, rb_addr, pci_rdata);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({rb_wr, rb_rd, pci_ack, loc_ack, rb_addr} !== 12'h0) begin
      fails++;
      $display("FAIL reset_idle: wr=%b rd=%b pack=%b lack=%b addr=%h, required all 0",
               rb_wr, rb_rd, pci_ack, loc_ack, rb_addr);
    end
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    pci_req = 1'b1; pci_wr = 1'b1; pci_addr = 6'h08; pci_be_n = 4'hE; pci_wdata = 32'h55;
    loc_req = 1'b1; loc_wr = 1'b1; loc_addr = 8'h50; loc_wdata = 8'h66;
    @(posedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h20, 8'h55}) begin
      fails++;
      $display("FAIL rr_first_pci: wr=%b addr=%h data=%h, required 1/20/55", rb_wr, rb_addr, rb_wdata);
    end
    @(negedge clk); tests++;
    if ({pci_ack, loc_ack} !== 2'b10) begin
      fails++;
      $display("FAIL rr_first_ack: pack=%b lack=%b, required 1/0", pci_ack, loc_ack);
    end
    @(negedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h50, 8'h66}) begin
      fails++;
      $display("FAIL rr_second_loc: wr=%b addr=%h data=%h, required 1/50/66", rb_wr, rb_addr, rb_wdata);
    end
    @(negedge clk); tests++;
    if ({pci_ack, loc_ack} !== 2'b01) begin
      fails++;
      $display("FAIL rr_second_ack: pack=%b lack=%b, required 0/1", pci_ack, loc_ack);
    end
    @(posedge clk); #1; loc_req = 1'b0;
    @(negedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr} !== {1'b1, 8'h20}) begin
      fails++;
      $display("FAIL rr_third_pci: wr=%b addr=%h, required 1/20", rb_wr, rb_addr);
    end
    @(negedge clk); tests++;
    if (pci_ack !== 1'b1) begin
      fails++;
      $display("FAIL rr_third_ack: pack=%b, required 1", pci_ack);
    end
    @(posedge clk); #1; pci_req = 1'b0;
  endtask

  task automatic test_pci_write_all;
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    pci_drive(1'b1, 6'h04, 4'h0, wd);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); tests++;
      if ({rb_wr, rb_rd, pci_ack, rb_addr, rb_wdata} !== {3'b100, 8'h10 + c[7:0], wd[c*8 +: 8]}) begin
        fails++;
        $display("FAIL wr_all_lane%0d: wr=%b rd=%b ack=%b addr=%h data=%h, required 1/0/0/%h/%h",
                 c, rb_wr, rb_rd, pci_ack, rb_addr, rb_wdata, 8'h10 + c[7:0], wd[c*8 +: 8]);
      end
    end
    @(negedge clk); tests++;
    if ({pci_ack, rb_wr} !== 2'b10) begin
      fails++;
      $display("FAIL wr_all_ack: ack=%b wr=%b, required 1/0", pci_ack, rb_wr);
    end
    @(posedge clk); #1; pci_req = 1'b0;
    tests++;
    if ({regf[8'h13], regf[8'h12], regf[8'h11], regf[8'h10]} !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_all_mem: got %h%h%h%h, required deadbeef",
               regf[8'h13], regf[8'h12], regf[8'h11], regf[8'h10]);
    end
  endtask

  task automatic test_pci_read_sparse;
    load(8'h00, 8'hEF); load(8'h01, 8'h11); load(8'h02, 8'hAD); load(8'h03, 8'h22);
    pci_drive(1'b0, 6'h00, 4'b1010, 32'h0);
    @(posedge clk);
    @(negedge clk); tests++;
    if ({rb_rd, rb_wr, rb_addr} !== {2'b10, 8'h00}) begin
      fails++;
      $display("FAIL rd_sparse_c1: rd=%b wr=%b addr=%h, required 1/0/00", rb_rd, rb_wr, rb_addr);
    end
    @(negedge clk); tests++;
    if ({rb_rd, rb_wr, rb_addr} !== {2'b10, 8'h02}) begin
      fails++;
      $display("FAIL rd_sparse_c2: rd=%b wr=%b addr=%h, required 1/0/02", rb_rd, rb_wr, rb_addr);
    end
    @(negedge clk); tests++;
    if ({rb_rd, rb_wr, pci_ack} !== 3'b000) begin
      fails++;
      $display("FAIL rd_sparse_c3: rd=%b wr=%b ack=%b, required 0/0/0", rb_rd, rb_wr, pci_ack);
    end
    @(negedge clk); tests++;
    if ({pci_ack, pci_rdata} !== {1'b1, 32'h00AD00EF}) begin
      fails++;
      $display("FAIL rd_sparse_ack: ack=%b rdata=%h, required 1/00ad00ef", pci_ack, pci_rdata);
    end
    @(posedge clk); #1; pci_req = 1'b0;
  endtask

  task automatic test_empty_enables;
    pci_drive(1'b0, 6'h01, 4'hF, 32'h0);
    @(posedge clk);
    @(negedge clk); tests++;
    if ({pci_ack, rb_rd, rb_wr, pci_rdata} !== {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL empty_ack: ack=%b rd=%b wr=%b rdata=%h, required 1/0/0/0",
               pci_ack, rb_rd, rb_wr, pci_rdata);
    end
    @(posedge clk); #1; pci_req = 1'b0;
    @(negedge clk); tests++;
    if (pci_ack !== 1'b0) begin
      fails++;
      $display("FAIL empty_ack_drop: ack=%b, required 0", pci_ack);
    end
  endtask

  task automatic test_local;
    loc_drive(1'b1, 8'h40, 8'h77);
    @(posedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_rd, loc_ack, rb_addr, rb_wdata} !== {3'b100, 8'h40, 8'h77}) begin
      fails++;
      $display("FAIL loc_wr_strobe: wr=%b rd=%b ack=%b addr=%h data=%h, required 1/0/0/40/77",
               rb_wr, rb_rd, loc_ack, rb_addr, rb_wdata);
    end
    @(negedge clk); tests++;
    if ({loc_ack, pci_ack, rb_wr} !== 3'b100) begin
      fails++;
      $display("FAIL loc_wr_ack: lack=%b pack=%b wr=%b, required 1/0/0", loc_ack, pci_ack, rb_wr);
    end
    @(posedge clk); #1; loc_req = 1'b0;
    loc_drive(1'b0, 8'h40, 8'h00);
    @(posedge clk);
    @(negedge clk); tests++;
    if ({rb_rd, rb_wr, rb_addr} !== {2'b10, 8'h40}) begin
      fails++;
      $display("FAIL loc_rd_strobe: rd=%b wr=%b addr=%h, required 1/0/40", rb_rd, rb_wr, rb_addr);
    end
    @(negedge clk); tests++;
    if ({rb_rd, loc_ack} !== 2'b00) begin
      fails++;
      $display("FAIL loc_rd_wait: rd=%b ack=%b, required 0/0", rb_rd, loc_ack);
    end
    @(negedge clk); tests++;
    if ({loc_ack, loc_rdata} !== {1'b1, 8'h77}) begin
      fails++;
      $display("FAIL loc_rd_ack: ack=%b rdata=%h, required 1/77", loc_ack, loc_rdata);
    end
    @(posedge clk); #1; loc_req = 1'b0;
  endtask

  task automatic test_abort;
    for (int i = 0; i < 4; i++) load(8'h30 + i[7:0], 8'h00);
    pci_drive(1'b1, 6'h0C, 4'h0, 32'h44332211);
    @(posedge clk); #1;
    loc_req = 1'b1; loc_wr = 1'b1; loc_addr = 8'h60; loc_wdata = 8'h99;
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h30, 8'h11}) begin
      fails++;
      $display("FAIL abort_c1: wr=%b addr=%h data=%h, required 1/30/11", rb_wr, rb_addr, rb_wdata);
    end
    @(posedge clk); #1; pci_abort = 1'b1;
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h31, 8'h22}) begin
      fails++;
      $display("FAIL abort_c2: wr=%b addr=%h data=%h, required 1/31/22", rb_wr, rb_addr, rb_wdata);
    end
    @(posedge clk); #1; pci_abort = 1'b0; pci_req = 1'b0;
    @(negedge clk); tests++;
    if ({rb_wr, rb_rd, pci_ack, loc_ack} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_idle: wr=%b rd=%b pack=%b lack=%b, required 0/0/0/0",
               rb_wr, rb_rd, pci_ack, loc_ack);
    end
    @(negedge clk); tests++;
    if ({rb_wr, pci_ack, rb_addr, rb_wdata} !== {2'b10, 8'h60, 8'h99}) begin
      fails++;
      $display("FAIL abort_loc_grant: wr=%b pack=%b addr=%h data=%h, required 1/0/60/99",
               rb_wr, pci_ack, rb_addr, rb_wdata);
    end
    @(negedge clk); tests++;
    if ({loc_ack, pci_ack} !== 2'b10) begin
      fails++;
      $display("FAIL abort_loc_ack: lack=%b pack=%b, required 1/0", loc_ack, pci_ack);
    end
    @(posedge clk); #1; loc_req = 1'b0;
    tests++;
    if ({regf[8'h33], regf[8'h32], regf[8'h31], regf[8'h30]} !== 32'h00002211) begin
      fails++;
      $display("FAIL abort_mem: got %h%h%h%h, required 00002211",
               regf[8'h33], regf[8'h32], regf[8'h31], regf[8'h30]);
    end
  endtask

  task automatic test_reset_mid_read;
    pci_drive(1'b1, 6'h02, 4'hE, 32'h000000C3);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); tests++;
    if (pci_ack !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_ack: ack=%b, required 1", pci_ack);
    end
    @(posedge clk); #1; pci_req = 1'b0;
    pci_drive(1'b0, 6'h00, 4'h0, 32'h0);
    @(posedge clk);
    @(posedge clk); #1; tests++;
    if ({rb_rd, rb_addr} !== {1'b1, 8'h01}) begin
      fails++;
      $display("FAIL rst_pre_strobe: rd=%b addr=%h, required 1/01", rb_rd, rb_addr);
    end
    #1; reset = 1'b0;
    #1; tests++;
    if ({rb_wr, rb_rd, pci_ack, loc_ack, rb_addr, rb_wdata, pci_rdata, loc_rdata} !== 58'h0) begin
      fails++;
      $display("FAIL rst_async_drop: wr=%b rd=%b pack=%b lack=%b addr=%h lrd=%h, required all 0",
               rb_wr, rb_rd, pci_ack, loc_ack, rb_addr, loc_rdata);
    end
    pci_req = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    pci_req = 1'b1; pci_wr = 1'b1; pci_addr = 6'h08; pci_be_n = 4'hE; pci_wdata = 32'hAA;
    loc_req = 1'b1; loc_wr = 1'b1; loc_addr = 8'h70; loc_wdata = 8'hBB;
    @(posedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h20, 8'hAA}) begin
      fails++;
      $display("FAIL rst_tie_pci: wr=%b addr=%h data=%h, required 1/20/aa", rb_wr, rb_addr, rb_wdata);
    end
    @(negedge clk);
    @(posedge clk); #1; pci_req = 1'b0;
    @(negedge clk);
    @(negedge clk); tests++;
    if ({rb_wr, rb_addr, rb_wdata} !== {1'b1, 8'h70, 8'hBB}) begin
      fails++;
      $display("FAIL rst_tie_loc: wr=%b addr=%h data=%h, required 1/70/bb", rb_wr, rb_addr, rb_wdata);
    end
    @(negedge clk); tests++;
    if (loc_ack !== 1'b1) begin
      fails++;
      $display("FAIL rst_tie_loc_ack: ack=%b, required 1", loc_ack);
    end
    @(posedge clk); #1; loc_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    pci_req = 1'b0; pci_wr = 1'b0; pci_addr = 6'h0; pci_be_n = 4'hF; pci_wdata = 32'h0;
    pci_abort = 1'b0;
    loc_req = 1'b0; loc_wr = 1'b0; loc_addr = 8'h0; loc_wdata = 8'h0;
    ld_en = 1'b0; ld_addr = 8'h0; ld_data = 8'h0;
    @(posedge clk);
    test_reset;
    test_round_robin;
    test_pci_write_all;
    test_pci_read_sparse;
    test_empty_enables;
    test_local;
    test_abort;
    test_reset_mid_read;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
